vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock and publishes the pixel position as `CounterX`/`CounterY`. It sits directly upstream of the key-bar region decoders, which compare `CounterY` against 32-line bands (15 bands = 480 active lines), and it drives the DAC sync/blank pins. All outputs are registered and mutually aligned.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: 50 MHz system clock
- `rst_n` in 1: asynchronous active-low reset
- `CounterX` out 12: horizontal position, 0..H_TOTAL-1
- `CounterY` out 12: vertical position, 0..V_TOTAL-1
- `pix_en` out 1: one-clock strobe, outputs hold a new pixel
- `hsync_n` out 1: horizontal sync, active low
- `vsync_n` out 1: vertical sync, active low
- `blank_n` out 1: high only inside the active area
- `line_start` out 1: pulse when `CounterX` becomes 0
- `frame_start` out 1: pulse when (`CounterX`,`CounterY`) becomes (0,0)
- `frame_cnt` out 8: frames completed, wraps 255→0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1; `tick` = (div == CLK_DIV-1). With CLK_DIV=1, tick is always high.
- On tick: `h` increments; at H_TOTAL-1 it wraps to 0 and `v` increments. `v` wraps from V_TOTAL-1 to 0, and `frame_cnt` increments in the same step.
- Decode from internal `h`/`v`:
  - hsync active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank_n = (h < H_ACTIVE) && (v < V_ACTIVE).
- During blanking, `CounterX`/`CounterY` carry raw counter values and are not clamped. Consumers gate with `blank_n`.
- Position arithmetic is 12-bit unsigned. Parameters must give H_TOTAL, V_TOTAL ≤ 4096.

## Timing
- Reset values: div=0, h=0, v=0, CounterX=0, CounterY=0, pix_en=0, hsync_n=1, vsync_n=1, blank_n=0, line_start=0, frame_start=0, frame_cnt=0.
- Output registers load on the clock after the internal counter update: one clock of latency from `h`/`v`. All outputs change on the same edge.
- `pix_en` is high for exactly one clock per pixel, on the clock the new values first appear. Period is CLK_DIV clocks.
- `line_start` and `frame_start` are high only in `pix_en` cycles whose outputs show X=0 (and Y=0 for `frame_start`).
- First pixel after reset release: counters already at (0,0), so the first `pix_en` after reset shows (1,0). `frame_start` first fires after one full frame.
- Asserting `rst_n` mid-frame forces all reset values immediately, independent of `clk`. Release is synchronised by the board-level reset bridge.
- Line period = 800×CLK_DIV clocks (1600). Frame period = 525 lines (840 000 clocks).

## Structure
- Shared package `vga_pkg`: default 640x480 timing constants, derived H_TOTAL/V_TOTAL, and the 12-bit coordinate width.
- One sub-module, `pix_clk_en`: parameterised modulo-CLK_DIV counter emitting `tick`.
- Counters, decode and output registers live in the top module.

## Test plan
- Reset, then run 2 lines → `pix_en` toggles every 2 clocks; `CounterX` goes 1..799, 0; `line_start` seen with CounterY=1.
- Check X=655/656/751/752 → `hsync_n` reads 1/0/0/1. Check X=639/640 → `blank_n` reads 1/0 (on Y<480).
- Run full frame → `vsync_n` low only for Y=490,491; `blank_n` low for all Y≥480; `frame_start` once at (0,0); frame period 840 000 clocks.
- Run 256 frames → `frame_cnt` goes 0→255→0.
- Assert `rst_n` at X=300, Y=200 → all outputs at reset values within the same cycle; restart from (0,0) after release.
- Set CLK_DIV=1 → `pix_en` constantly high; line period 800 clocks; sync positions unchanged in pixel terms.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz timing constants and the coordinate type shared by
// the VGA raster generator.
package vga_pkg;

   localparam int unsigned COORD_W = 12;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Half-open window test used for the sync decodes: lo <= val < hi.
   function automatic logic in_range(input coord_t val, input coord_t lo, input coord_t hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Modulo-CLK_DIV counter that emits a one-clock tick per pixel period.
module pix_clk_en #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   // With CLK_DIV=1 the counter is a constant 0 and tick stays high.
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line/frame counters, sync and blank decode, and a
// registered output stage that presents every output on the same edge.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [COORD_W-1:0] CounterX,
   output logic [COORD_W-1:0] CounterY,
   output logic               pix_en,
   output logic               hsync_n,
   output logic               vsync_n,
   output logic               blank_n,
   output logic               line_start,
   output logic               frame_start,
   output logic [7:0]         frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam coord_t V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam coord_t H_VIS    = COORD_W'(H_ACTIVE);
   localparam coord_t V_VIS    = COORD_W'(V_ACTIVE);
   localparam coord_t HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   logic       tick;
   logic       tick_q;
   coord_t     h;
   coord_t     v;
   logic [7:0] frame_q;
   logic       hsync_act;
   logic       vsync_act;
   logic       active;

   pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // tick_q marks the clock right after a counter step; the output stage loads then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h       <= '0;
         v       <= '0;
         frame_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= tick;
         if (tick) begin
            if (h == H_LAST) begin
               h <= '0;
               if (v == V_LAST) begin
                  v       <= '0;
                  frame_q <= frame_q + 8'd1;
               end else begin
                  v <= v + 1'b1;
               end
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   always_comb begin
      hsync_act = in_range(h, HS_START, HS_END);
      vsync_act = in_range(v, VS_START, VS_END);
      active    = (h < H_VIS) && (v < V_VIS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CounterX    <= '0;
         CounterY    <= '0;
         pix_en      <= 1'b0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         blank_n     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         pix_en      <= tick_q;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (tick_q) begin
            CounterX    <= h;
            CounterY    <= v;
            hsync_n     <= !hsync_act;
            vsync_n     <= !vsync_act;
            blank_n     <= active;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
            frame_cnt   <= frame_q;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a CLK_DIV=1 variant and a
// miniature raster (8x6 totals) that makes whole-frame behaviour cheap to run.
module tb_vga_timing_gen;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   localparam logic [37:0] RST_VAL = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

   logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic        a_pix, a_hs, a_vs, a_bl, a_ls, a_fs;
   logic        b_pix, b_hs, b_vs, b_bl, b_ls, b_fs;
   logic        c_pix, c_hs, c_vs, c_bl, c_ls, c_fs;
   logic [7:0]  a_fc, b_fc, c_fc;
   logic [37:0] a_all, b_all, c_all;

   assign a_all = {a_x, a_y, a_pix, a_hs, a_vs, a_bl, a_ls, a_fs, a_fc};
   assign b_all = {b_x, b_y, b_pix, b_hs, b_vs, b_bl, b_ls, b_fs, b_fc};
   assign c_all = {c_x, c_y, c_pix, c_hs, c_vs, c_bl, c_ls, c_fs, c_fc};

   vga_timing_gen dut_a (
      .clk(clk), .rst_n(rst_n), .CounterX(a_x), .CounterY(a_y), .pix_en(a_pix),
      .hsync_n(a_hs), .vsync_n(a_vs), .blank_n(a_bl), .line_start(a_ls),
      .frame_start(a_fs), .frame_cnt(a_fc)
   );

   vga_timing_gen #(.CLK_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .CounterX(b_x), .CounterY(b_y), .pix_en(b_pix),
      .hsync_n(b_hs), .vsync_n(b_vs), .blank_n(b_bl), .line_start(b_ls),
      .frame_start(b_fs), .frame_cnt(b_fc)
   );

   // H: 4 active, hsync at h=5..6, total 8.  V: 3 active, vsync at v=4, total 6.
   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .CounterX(c_x), .CounterY(c_y), .pix_en(c_pix),
      .hsync_n(c_hs), .vsync_n(c_vs), .blank_n(c_bl), .line_start(c_ls),
      .frame_start(c_fs), .frame_cnt(c_fc)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (a_all !== RST_VAL) begin errors++; $display("FAIL reset_a: got %h expected %h", a_all, RST_VAL); end
      checks++; if (b_all !== RST_VAL) begin errors++; $display("FAIL reset_b: got %h expected %h", b_all, RST_VAL); end
      checks++; if (c_all !== RST_VAL) begin errors++; $display("FAIL reset_c: got %h expected %h", c_all, RST_VAL); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (a_all !== RST_VAL) begin errors++; $display("FAIL hold_a: got %h expected %h", a_all, RST_VAL); end
      checks++; if (c_all !== RST_VAL) begin errors++; $display("FAIL hold_c: got %h expected %h", c_all, RST_VAL); end
   endtask

   task automatic test_two_lines();
      int   p, ex, ey;
      logic exp_pix;
      int   ls_k[$];
      apply_reset();
      for (int k = 1; k <= 3201; k++) begin
         @(negedge clk);
         exp_pix = (k >= 3) && (k % 2 == 1);
         checks++;
         if (a_pix !== exp_pix) begin errors++; $display("FAIL pix_en_a k=%0d: got %b expected %b", k, a_pix, exp_pix); end
         if (exp_pix) begin
            p  = (k - 1) / 2;
            ex = p % 800;
            ey = p / 800;
            checks++;
            if (a_x !== 12'(ex) || a_y !== 12'(ey)) begin
               errors++; $display("FAIL pos_a k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, a_x, a_y, ex, ey);
            end
            checks++;
            if (a_ls !== (ex == 0) || a_fs !== 1'b0) begin
               errors++; $display("FAIL strobes_a k=%0d: got ls=%b fs=%b expected ls=%b fs=0", k, a_ls, a_fs, (ex == 0));
            end
            if (a_ls === 1'b1) ls_k.push_back(k);
         end else begin
            checks++;
            if (a_ls !== 1'b0 || a_fs !== 1'b0) begin
               errors++; $display("FAIL idle_strobes_a k=%0d: got ls=%b fs=%b expected 0/0", k, a_ls, a_fs);
            end
         end
      end
      checks++;
      if (ls_k.size() != 2) begin
         errors++; $display("FAIL line_start_count_a: got %0d expected 2", ls_k.size());
      end else begin
         checks++;
         if (ls_k[1] - ls_k[0] != 1600) begin
            errors++; $display("FAIL line_period_a: got %0d expected 1600", ls_k[1] - ls_k[0]);
         end
      end
   endtask

   task automatic test_h_boundaries();
      int   tx[6];
      logic ehs[6];
      logic ebl[6];
      logic found;
      tx  = '{639, 640, 655, 656, 751, 752};
      ehs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      ebl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         found = 1'b0;
         for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (a_pix === 1'b1 && a_x === 12'(tx[i])) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++; $display("FAIL h_wait X=%0d: got timeout expected pixel", tx[i]);
         end else begin
            checks++;
            if (a_hs !== ehs[i]) begin errors++; $display("FAIL hsync X=%0d: got %b expected %b", tx[i], a_hs, ehs[i]); end
            checks++;
            if (a_bl !== ebl[i]) begin errors++; $display("FAIL blank X=%0d: got %b expected %b", tx[i], a_bl, ebl[i]); end
         end
      end
   endtask

   task automatic test_clk_div1();
      int   p, ex, ey;
      logic exp_pix, exp_hs;
      int   ls_k[$];
      apply_reset();
      for (int k = 1; k <= 1601; k++) begin
         @(negedge clk);
         exp_pix = (k >= 2);
         checks++;
         if (b_pix !== exp_pix) begin errors++; $display("FAIL pix_en_b k=%0d: got %b expected %b", k, b_pix, exp_pix); end
         if (exp_pix) begin
            p      = k - 1;
            ex     = p % 800;
            ey     = p / 800;
            exp_hs = !(ex >= 656 && ex < 752);
            checks++;
            if (b_x !== 12'(ex) || b_y !== 12'(ey)) begin
               errors++; $display("FAIL pos_b k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, b_x, b_y, ex, ey);
            end
            checks++;
            if (b_hs !== exp_hs || b_bl !== (ex < 640)) begin
               errors++; $display("FAIL decode_b X=%0d: got hs=%b bl=%b expected hs=%b bl=%b", ex, b_hs, b_bl, exp_hs, (ex < 640));
            end
            if (b_ls === 1'b1) ls_k.push_back(k);
         end
      end
      checks++;
      if (ls_k.size() != 2) begin
         errors++; $display("FAIL line_start_count_b: got %0d expected 2", ls_k.size());
      end else begin
         checks++;
         if (ls_k[1] - ls_k[0] != 800) begin
            errors++; $display("FAIL line_period_b: got %0d expected 800", ls_k[1] - ls_k[0]);
         end
      end
   endtask

   task automatic test_full_frame();
      int         p, ex, ey;
      logic       exp_pix, exp_vs, exp_hs, exp_bl, exp_fs;
      logic [7:0] exp_fc;
      int         fs_k[$];
      apply_reset();
      for (int k = 1; k <= 193; k++) begin
         @(negedge clk);
         exp_pix = (k >= 3) && (k % 2 == 1);
         checks++;
         if (c_pix !== exp_pix) begin errors++; $display("FAIL pix_en_c k=%0d: got %b expected %b", k, c_pix, exp_pix); end
         if (exp_pix) begin
            p      = (k - 1) / 2;
            ex     = p % 8;
            ey     = (p / 8) % 6;
            exp_vs = (ey != 4);
            exp_hs = !(ex == 5 || ex == 6);
            exp_bl = (ex < 4) && (ey < 3);
            exp_fs = (p % 48 == 0);
            exp_fc = 8'(p / 48);
            checks++;
            if (c_x !== 12'(ex) || c_y !== 12'(ey)) begin
               errors++; $display("FAIL pos_c k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, c_x, c_y, ex, ey);
            end
            checks++;
            if ({c_hs, c_vs, c_bl, c_fs} !== {exp_hs, exp_vs, exp_bl, exp_fs}) begin
               errors++; $display("FAIL decode_c (%0d,%0d): got hs/vs/bl/fs=%b%b%b%b expected %b%b%b%b",
                                  ex, ey, c_hs, c_vs, c_bl, c_fs, exp_hs, exp_vs, exp_bl, exp_fs);
            end
            checks++;
            if (c_fc !== exp_fc) begin errors++; $display("FAIL frame_cnt_c p=%0d: got %0d expected %0d", p, c_fc, exp_fc); end
            if (c_fs === 1'b1) fs_k.push_back(k);
         end
      end
      checks++;
      if (fs_k.size() != 2) begin
         errors++; $display("FAIL frame_start_count_c: got %0d expected 2", fs_k.size());
      end else begin
         checks++;
         if (fs_k[1] - fs_k[0] != 96) begin
            errors++; $display("FAIL frame_period_c: got %0d expected 96", fs_k[1] - fs_k[0]);
         end
      end
   endtask

   task automatic test_frame_count();
      logic found;
      apply_reset();
      for (int i = 1; i <= 256; i++) begin
         found = 1'b0;
         for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (c_fs === 1'b1) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++; $display("FAIL frame_wait #%0d: got timeout expected frame_start", i);
            break;
         end
         checks++;
         if (c_fc !== 8'(i)) begin errors++; $display("FAIL frame_cnt #%0d: got %0d expected %0d", i, c_fc, 8'(i)); end
      end
   endtask

   task automatic test_async_reset();
      logic found;
      apply_reset();
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (c_pix === 1'b1 && c_x === 12'd5 && c_y === 12'd2) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL async_wait: got timeout expected (5,2)"); end
      // Reset lands between clock edges; outputs must clear without a posedge.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_all !== RST_VAL) begin errors++; $display("FAIL async_a: got %h expected %h", a_all, RST_VAL); end
      checks++; if (b_all !== RST_VAL) begin errors++; $display("FAIL async_b: got %h expected %h", b_all, RST_VAL); end
      checks++; if (c_all !== RST_VAL) begin errors++; $display("FAIL async_c: got %h expected %h", c_all, RST_VAL); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) begin
            checks++;
            if (c_all !== RST_VAL) begin errors++; $display("FAIL restart_hold k=%0d: got %h expected %h", k, c_all, RST_VAL); end
         end else begin
            checks++;
            if ({c_pix, c_x, c_y, c_bl} !== {1'b1, 12'd1, 12'd0, 1'b1}) begin
               errors++; $display("FAIL restart_first: got pix=%b (%0d,%0d) bl=%b expected pix=1 (1,0) bl=1", c_pix, c_x, c_y, c_bl);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_lines();
      test_h_boundaries();
      test_clk_div1();
      test_full_frame();
      test_frame_count();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
